// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s execution units used by the iterative multiplier.
package cv32e40s_pkg;

   typedef enum logic [0:0] {
      MUL_M32 = 1'b0,
      MUL_H   = 1'b1
   } mul_opcode_e;

   typedef enum logic [0:0] {
      MI_CALC = 1'b0,
      MI_LAST = 1'b1
   } mult_state_e;

   // Iteration counter width; a single-iteration multiplier still keeps one bit.
   function automatic int unsigned mult_cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cv32e40s_mult_pp.sv
// One partial product: the extended multiplicand times the selected multiplier slice.
module cv32e40s_mult_pp
   import cv32e40s_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PP_W  = 8,
   parameter int unsigned CNT_W = 2
) (
   input  logic [XLEN-1:0]      op_a,
   input  logic [XLEN-1:0]      op_b,
   input  logic [1:0]           signed_mode,
   input  logic [CNT_W-1:0]     idx,
   output logic [XLEN+PP_W+1:0] pp
);

   localparam int unsigned N        = XLEN / PP_W;
   localparam int unsigned PP_WIDTH = XLEN + PP_W + 2;

   logic [XLEN-1:0]            b_shifted;
   logic [PP_W-1:0]            b_slice;
   logic                       a_sign;
   logic                       b_sign;
   logic signed [PP_WIDTH-1:0] a_wide;
   logic signed [PP_WIDTH-1:0] b_wide;

   // Only the top slice of op_b carries its sign; lower slices are unsigned magnitudes.
   always_comb begin
      b_shifted = op_b >> (PP_W * 32'(idx));
      b_slice   = b_shifted[PP_W-1:0];
      a_sign    = signed_mode[0] & op_a[XLEN-1];
      b_sign    = (idx == CNT_W'(N - 1)) & signed_mode[1] & op_b[XLEN-1];
      a_wide    = {{(PP_W + 1){a_sign}}, a_sign, op_a};
      b_wide    = {{(XLEN + 1){b_sign}}, b_sign, b_slice};
      pp        = a_wide * b_wide;
   end

endmodule

// File: rtl/cv32e40s_mult_iter.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, one op_b slice per cycle,
// with an optional single-cycle path for the low-half MUL.
module cv32e40s_mult_iter
   import cv32e40s_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned PP_W     = 8,
   parameter bit          FAST_MUL = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  mul_opcode_e       operator_i,
   input  logic [1:0]        signed_mode_i,
   input  logic [XLEN-1:0]   op_a_i,
   input  logic [XLEN-1:0]   op_b_i,
   output logic [XLEN-1:0]   result_o,
   output logic              valid_o,
   output logic              ready_o,
   input  logic              ready_i
);

   localparam int unsigned N        = XLEN / PP_W;
   localparam int unsigned CNT_W    = mult_cnt_w(N);
   localparam int unsigned ACC_W    = 2 * XLEN + 2;
   localparam int unsigned PP_WIDTH = XLEN + PP_W + 2;
   localparam mult_state_e INIT_STATE = (N == 1) ? MI_LAST : MI_CALC;

   mult_state_e         state;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [PP_WIDTH-1:0] pp;
   logic [ACC_W-1:0]    pp_ext;
   logic [ACC_W-1:0]    sum;
   int unsigned         shamt;
   logic                fast_op;
   logic [XLEN-1:0]     fast_res;

   cv32e40s_mult_pp #(
      .XLEN  (XLEN),
      .PP_W  (PP_W),
      .CNT_W (CNT_W)
   ) u_pp (
      .op_a        (op_a_i),
      .op_b        (op_b_i),
      .signed_mode (signed_mode_i),
      .idx         (cnt),
      .pp          (pp)
   );

   // Weight the current partial product by its slice position and add it in.
   always_comb begin
      shamt  = PP_W * 32'(cnt);
      pp_ext = ACC_W'($signed(pp));
      sum    = acc + (pp_ext << shamt);
   end

   // Handshake and result selection; the fast path bypasses the FSM entirely.
   always_comb begin
      fast_op  = FAST_MUL && (operator_i == MUL_M32);
      fast_res = op_a_i * op_b_i;
      valid_o  = valid_i && (fast_op || (state == MI_LAST));
      ready_o  = !valid_i || (valid_o && ready_i);
      if (fast_op) begin
         result_o = fast_res;
      end else if (operator_i == MUL_M32) begin
         result_o = sum[XLEN-1:0];
      end else begin
         result_o = sum[2*XLEN-1:XLEN];
      end
   end

   // Iteration FSM: a dropped valid_i kills the op, a fast op keeps the FSM idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT_STATE;
         acc   <= '0;
         cnt   <= '0;
      end else if (!valid_i || fast_op) begin
         state <= INIT_STATE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            MI_CALC: begin
               acc <= sum;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N - 2)) begin
                  state <= MI_LAST;
               end
            end
            MI_LAST: begin
               if (ready_i) begin
                  state <= INIT_STATE;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= INIT_STATE;
            end
         endcase
      end
   end

   a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_o && !ready_i) |=> (!valid_i || $stable(result_o)));

   a_inputs_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_i && !ready_o) |=> (!valid_i || ($stable(op_a_i) && $stable(op_b_i) &&
                                 $stable(operator_i) && $stable(signed_mode_i))));

   if (N > 1) begin : g_no_early
      a_no_early_high: assert property (@(posedge clk) disable iff (!rst_n)
         (valid_i && (operator_i == MUL_H) && (state == MI_CALC) && (cnt == '0)) |-> !valid_o);
   end

endmodule

// File: tb/tb_cv32e40s_mult_iter.sv
// Bench for cv32e40s_mult_iter: four configurations checked against a full-width product model.
module tb_cv32e40s_mult_iter;
   import cv32e40s_pkg::*;

   localparam int NCH = 4;
   localparam int CH_N [NCH] = '{4, 4, 2, 1};

   logic clk;
   logic rst_n;
   logic [NCH-1:0]        v;
   logic [NCH-1:0]        rdy;
   logic [NCH-1:0]        vo;
   logic [NCH-1:0]        ro;
   logic [NCH-1:0][31:0]  res;
   mul_opcode_e           opr  [NCH];
   logic [1:0]            sm   [NCH];
   logic [31:0]           a_in [NCH];
   logic [31:0]           b_in [NCH];

   int checks   = 0;
   int failures = 0;
   bit started  = 0;
   int age [NCH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ch0: PP_W=8, ch1: PP_W=8 with fast MUL, ch2: PP_W=16, ch3: PP_W=32
   for (genvar g = 0; g < NCH; g++) begin : g_dut
      localparam int unsigned PPW = (g == 2) ? 16 : ((g == 3) ? 32 : 8);
      localparam bit FST = (g == 1);
      cv32e40s_mult_iter #(.XLEN(32), .PP_W(PPW), .FAST_MUL(FST)) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .valid_i       (v[g]),
         .operator_i    (opr[g]),
         .signed_mode_i (sm[g]),
         .op_a_i        (a_in[g]),
         .op_b_i        (b_in[g]),
         .result_o      (res[g]),
         .valid_o       (vo[g]),
         .ready_o       (ro[g]),
         .ready_i       (rdy[g])
      );
   end

   function automatic logic [31:0] ref_mul(input mul_opcode_e op, input logic [1:0] smode,
                                           input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] as;
      logic signed [65:0] bs;
      logic signed [65:0] p;
      as = smode[0] ? {{34{a[31]}}, a} : {34'b0, a};
      bs = smode[1] ? {{34{b[31]}}, b} : {34'b0, b};
      p  = as * bs;
      return (op == MUL_M32) ? p[31:0] : p[63:32];
   endfunction

   function automatic int lat_of(input int ch, input mul_opcode_e op);
      if (ch == 1 && op == MUL_M32) return 0;
      return CH_N[ch] - 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Model: an op has been in flight for age cycles; it shows its result once age reaches its latency.
   always @(posedge clk) begin
      for (int ch = 0; ch < NCH; ch++) begin
         if (!rst_n || !v[ch]) age[ch] = 0;
         else if (age[ch] >= lat_of(ch, opr[ch]) && rdy[ch]) age[ch] = 0;
         else age[ch] = age[ch] + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && started) begin
         for (int ch = 0; ch < NCH; ch++) begin
            logic ev;
            logic er;
            ev = v[ch] && (age[ch] >= lat_of(ch, opr[ch]));
            er = !v[ch] || (ev && rdy[ch]);
            chk($sformatf("cmp_valid_ch%0d", ch), 32'(vo[ch]), 32'(ev));
            chk($sformatf("cmp_ready_ch%0d", ch), 32'(ro[ch]), 32'(er));
            if (ev) chk($sformatf("cmp_result_ch%0d", ch), res[ch],
                        ref_mul(opr[ch], sm[ch], a_in[ch], b_in[ch]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      v = '0;
      repeat (n) step();
   endtask

   task automatic wait_result(input int ch, input logic [31:0] exp, input int exp_lat,
                              input string name);
      bit got = 0;
      int c = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (vo[ch]) begin
            got = 1;
            c = i;
            break;
         end
         step();
      end
      chk({name, "_seen"}, 32'(got), 32'd1);
      chk({name, "_result"}, res[ch], exp);
      chk({name, "_latency"}, 32'(c), 32'(exp_lat));
      step();
   endtask

   task automatic start_op(input int ch, input mul_opcode_e op, input logic [1:0] smode,
                           input logic [31:0] a, input logic [31:0] b);
      opr[ch]  = op;
      sm[ch]   = smode;
      a_in[ch] = a;
      b_in[ch] = b;
      rdy[ch]  = 1'b1;
      v[ch]    = 1'b1;
   endtask

   task automatic run_op(input int ch, input mul_opcode_e op, input logic [1:0] smode,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
      start_op(ch, op, smode, a, b);
      wait_result(ch, exp, exp_lat, name);
   endtask

   initial begin
      rst_n = 1'b0;
      v     = '0;
      rdy   = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         opr[ch]  = MUL_M32;
         sm[ch]   = 2'b00;
         a_in[ch] = '0;
         b_in[ch] = '0;
         age[ch]  = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      started = 1;

      @(negedge clk);
      chk("reset_valid_ch0", 32'(vo[0]), 32'd0);
      chk("reset_ready_ch0", 32'(ro[0]), 32'd1);
      chk("reset_valid_ch3", 32'(vo[3]), 32'd0);
      step();

      chk("model_mulh_min",  ref_mul(MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      chk("model_mulhu_max", ref_mul(MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      chk("model_mulhsu",    ref_mul(MUL_H, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

      run_op(0, MUL_M32, 2'b00, 32'h7, 32'h6, 32'h2A, 3, "t1_mul");
      idle(1);
      run_op(1, MUL_M32, 2'b00, 32'h7, 32'h6, 32'h2A, 0, "t1_fast_mul");
      run_op(1, MUL_H, 2'b11, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 3, "t1_fast_mulh");
      idle(1);

      run_op(0, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3, "t2_mulh_min");
      run_op(0, MUL_H, 2'b11, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 3, "t2_mulh_neg");
      run_op(0, MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, "t3_mulhu");
      run_op(0, MUL_H, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "t3_mulhsu");
      idle(1);

      // Downstream stalls for three cycles while the result is presented.
      start_op(0, MUL_H, 2'b00, 32'h8000_0000, 32'h4);
      rdy[0] = 1'b0;
      repeat (3) step();
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("t4_stall_valid_%0d", s), 32'(vo[0]), 32'd1);
         chk($sformatf("t4_stall_ready_%0d", s), 32'(ro[0]), 32'd0);
         chk($sformatf("t4_stall_result_%0d", s), res[0], 32'h2);
         step();
      end
      rdy[0] = 1'b1;
      @(negedge clk);
      chk("t4_accept_ready", 32'(ro[0]), 32'd1);
      chk("t4_accept_result", res[0], 32'h2);
      step();
      run_op(0, MUL_M32, 2'b00, 32'h1_0000, 32'h1_0000, 32'h0, 3, "t4_b2b_mul");
      run_op(0, MUL_H, 2'b11, 32'h1_0000, 32'h1_0000, 32'h1, 3, "t4_b2b_mulh");
      idle(1);

      // Kill while the counter sits at 2.
      start_op(0, MUL_H, 2'b11, 32'h1234, 32'h5678);
      repeat (2) step();
      v[0] = 1'b0;
      @(negedge clk);
      chk("t5_kill_ready", 32'(ro[0]), 32'd1);
      chk("t5_kill_valid", 32'(vo[0]), 32'd0);
      step();
      run_op(0, MUL_H, 2'b00, 32'h2, 32'h8000_0000, 32'h1, 3, "t5_after_kill");
      idle(1);

      // Reset in the middle of an op; the op restarts from scratch afterwards.
      start_op(0, MUL_M32, 2'b00, 32'h3, 32'h5);
      repeat (2) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wait_result(0, 32'hF, 3, "t7_reset_mid_op");
      idle(1);

      for (int ch = 1; ch < NCH; ch++) begin
         for (int k = 0; k < 12; k++) begin
            mul_opcode_e op;
            logic [1:0]  smode;
            logic [31:0] a;
            logic [31:0] b;
            op    = mul_opcode_e'($urandom_range(0, 1));
            smode = 2'($urandom_range(0, 3));
            a     = (k == 0) ? 32'h8000_0000 : $urandom;
            b     = (k == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(ch, op, smode, a, b, ref_mul(op, smode, a, b), lat_of(ch, op),
                   $sformatf("t6_ch%0d_op%0d", ch, k));
         end
         idle(1);
      end

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
